// File: rtl/ifconv_wb_queue_pkg.sv
// Shared types for the int-to-float writeback queue: ptype encoding, result width, queue entry layout.
package ifconv_wb_queue_pkg;

   localparam int RES_W      = 82;
   localparam int DFLT_TAG_W = 9;

   typedef enum logic [1:0] {
      PTYPE_SNGL = 2'd0,
      PTYPE_DBL  = 2'd1,
      PTYPE_EXT  = 2'd2
   } ptype_e;

   typedef struct packed {
      logic [RES_W-1:0]      res;
      logic [1:0]            rtyp;
      logic [DFLT_TAG_W-1:0] tag;
   } wb_entry_t;

   // Flat width of one queue entry for an arbitrary tag width.
   function automatic int entry_w(input int tag_w);
      return RES_W + 2 + tag_w;
   endfunction

endpackage

// File: rtl/ifconv_wb_fifo.sv
// DEPTH x W storage with wrapping pointers and occupancy; 1-cycle write-to-read, no bypass.
// Push when full is dropped unless a pop happens in the same cycle; pop when empty is ignored.
module ifconv_wb_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdat,
   output logic [W-1:0]             rdat,
   output logic [$clog2(DEPTH):0]   occ,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (occ == CW'(DEPTH));
   assign empty   = (occ == '0);
   assign do_pop  = pop & ~empty;
   // When full, the write lands on the slot being popped; the read port still shows the old entry this cycle.
   assign do_push = push & (~full | do_pop);
   assign rdat    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         occ <= occ + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdat;
   end

endmodule

// File: rtl/ifconv_wb_queue.sv
// Aligns issue tags with the 2-stage converter result and queues results for FP writeback; issue to wb_vld is 2 clkEn edges.
// The converter cannot stall, so issue is throttled by can_issue credits; writeback drains with wb_vld/wb_rdy independent of clkEn.
module ifconv_wb_queue
   import ifconv_wb_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = DFLT_TAG_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clkEn,
   input  logic                   en_in,
   input  logic [TAG_W-1:0]       tag_in,
   input  logic [RES_W-1:0]       res,
   input  logic [1:0]             rtyp,
   output logic                   can_issue,
   output logic                   wb_vld,
   input  logic                   wb_rdy,
   output logic [RES_W-1:0]       wb_res,
   output logic [1:0]             wb_rtyp,
   output logic [TAG_W-1:0]       wb_tag,
   output logic [$clog2(DEPTH):0] occ,
   output logic                   ovf
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = entry_w(TAG_W);

   logic             v1;
   logic             v2;
   logic [TAG_W-1:0] tag1;
   logic [TAG_W-1:0] tag2;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   logic [EW-1:0]    wdat;
   logic [EW-1:0]    rdat;
   logic [CW:0]      committed;

   // Delay line mirrors the converter's two register stages, including its stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1   <= 1'b0;
         v2   <= 1'b0;
         tag1 <= '0;
         tag2 <= '0;
      end else if (clkEn) begin
         v1   <= en_in;
         tag1 <= tag_in;
         v2   <= v1;
         tag2 <= tag1;
      end
   end

   assign push = clkEn & v2;
   assign pop  = wb_vld & wb_rdy;
   assign wdat = {res, rtyp, tag2};

   assign {wb_res, wb_rtyp, wb_tag} = rdat;
   assign wb_vld = ~empty;

   // Credits count queued entries plus conversions still inside the converter; one extra bit avoids wrap.
   assign committed = {1'b0, occ} + (CW+1)'(v1) + (CW+1)'(v2);
   assign can_issue = (committed < (CW+1)'(DEPTH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if ((en_in & clkEn & ~can_issue) | (push & full & ~pop)) begin
         ovf <= 1'b1;
      end
   end

   ifconv_wb_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdat  (wdat),
      .rdat  (rdat),
      .occ   (occ),
      .full  (full),
      .empty (empty)
   );

endmodule

// File: tb/tb_ifconv_wb_queue.sv
// Table-driven bench for ifconv_wb_queue with a converter model on res/rtyp and an in-order writeback scoreboard.
module tb_ifconv_wb_queue;
   import ifconv_wb_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int TAG_W = 9;
   localparam logic [81:0] RES_BASE = 82'h1_3FFF_8000_0000_0000_0000;
   localparam logic [81:0] GARB     = 82'h3_DEAD_BEEF_0BAD_F00D_1234;

   logic             clk = 1'b0;
   logic             rst;
   logic             clkEn;
   logic             en_in;
   logic [TAG_W-1:0] tag_in;
   logic [81:0]      res;
   logic [1:0]       rtyp;
   logic             can_issue;
   logic             wb_vld;
   logic             wb_rdy;
   logic [81:0]      wb_res;
   logic [1:0]       wb_rtyp;
   logic [TAG_W-1:0] wb_tag;
   logic [2:0]       occ;
   logic             ovf;
   logic             garb;

   typedef struct {
      logic             en;
      logic [TAG_W-1:0] tag;
      logic             ce;
      logic             rdy;
      logic             garb;
      logic             drop;
      logic [2:0]       occ;
      logic             can;
      logic             vld;
      logic             ovf;
   } vec_t;

   vec_t      tbl[$];
   wb_entry_t sb[$];
   int        nvec = 0;
   int        nerr = 0;

   ifconv_wb_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .clkEn     (clkEn),
      .en_in     (en_in),
      .tag_in    (tag_in),
      .res       (res),
      .rtyp      (rtyp),
      .can_issue (can_issue),
      .wb_vld    (wb_vld),
      .wb_rdy    (wb_rdy),
      .wb_res    (wb_res),
      .wb_rtyp   (wb_rtyp),
      .wb_tag    (wb_tag),
      .occ       (occ),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [81:0] res_of(input logic [TAG_W-1:0] t);
      logic [81:0] x;
      x = 82'(t ^ 9'h005);
      return RES_BASE ^ (x << 24);
   endfunction

   function automatic logic [1:0] rtyp_of(input logic [TAG_W-1:0] t);
      logic [TAG_W-1:0] m;
      m = t % 9'd3;
      return m[1:0];
   endfunction

   // Converter model: result for the conversion issued two clkEn edges earlier.
   logic [TAG_W-1:0] m_tag1 = '0;
   logic [TAG_W-1:0] m_tag2 = '0;
   always @(posedge clk) begin
      if (clkEn === 1'b1) begin
         m_tag1 <= tag_in;
         m_tag2 <= m_tag1;
      end
   end
   always_comb begin
      res  = garb ? GARB : res_of(m_tag2);
      rtyp = garb ? 2'd3 : rtyp_of(m_tag2);
   end

   task automatic chk(input string name, input logic [81:0] act, input logic [81:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int en, tag, ce, rdy, gb, drop, oc, can, vld, ov);
      vec_t v;
      v.en   = 1'(en);
      v.tag  = 9'(tag);
      v.ce   = 1'(ce);
      v.rdy  = 1'(rdy);
      v.garb = 1'(gb);
      v.drop = 1'(drop);
      v.occ  = 3'(oc);
      v.can  = 1'(can);
      v.vld  = 1'(vld);
      v.ovf  = 1'(ov);
      return v;
   endfunction

   task automatic monitor();
      wb_entry_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && wb_vld === 1'b1 && wb_rdy === 1'b1) begin
            if (sb.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL unexpected_pop: got tag %h expected no entry", wb_tag);
            end else begin
               e = sb.pop_front();
               chk($sformatf("wb_tag(exp %0d)", e.tag), 82'(wb_tag), 82'(e.tag));
               chk($sformatf("wb_res(tag %0d)", e.tag), wb_res, e.res);
               chk($sformatf("wb_rtyp(tag %0d)", e.tag), 82'(wb_rtyp), 82'(e.rtyp));
            end
         end
      end
   endtask

   // Called just after a rising edge; expectations describe state after the next edge.
   task automatic apply_row(input vec_t v, input int idx);
      wb_entry_t e;
      en_in  = v.en;
      tag_in = v.tag;
      clkEn  = v.ce;
      wb_rdy = v.rdy;
      garb   = v.garb;
      if (v.en && v.ce && !v.drop) begin
         e.tag  = v.tag;
         e.res  = res_of(v.tag);
         e.rtyp = rtyp_of(v.tag);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      chk($sformatf("occ[%0d]", idx),       82'(occ),       82'(v.occ));
      chk($sformatf("can_issue[%0d]", idx), 82'(can_issue), 82'(v.can));
      chk($sformatf("wb_vld[%0d]", idx),    82'(wb_vld),    82'(v.vld));
      chk($sformatf("ovf[%0d]", idx),       82'(ovf),       82'(v.ovf));
   endtask

   initial begin
      rst = 1'b1; clkEn = 1'b0; en_in = 1'b0; tag_in = '0; wb_rdy = 1'b0; garb = 1'b0;
      fork
         monitor();
      join_none

      // single issue, tag 5
      tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
      // stall right after issue of tag 7; garbage on res until the real push edge
      tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 1, 0, 0));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
      // stall while the result is at the output stage: no push without clkEn
      tbl.push_back(mk(1, 8, 1, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
      // streaming tags 0..7 with the port always ready; pointers wrap twice
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(1, i, 1, 1, 0, 0, (i < 2) ? 0 : 1, 1, (i < 2) ? 0 : 1, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
      // back-pressure fill: credits run out after 4 issues
      tbl.push_back(mk(1, 16, 1, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 17, 1, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 18, 1, 0, 0, 0, 1, 1, 1, 0));
      tbl.push_back(mk(1, 19, 1, 0, 0, 0, 2, 0, 1, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3, 0, 1, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 4, 0, 1, 0));
      // protocol violation: tag 20 lands as full push+pop, tag 21 hits a full queue and is dropped
      tbl.push_back(mk(1, 20, 1, 0, 0, 0, 4, 0, 1, 1));
      tbl.push_back(mk(1, 21, 1, 0, 0, 1, 4, 0, 1, 1));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 4, 0, 1, 1));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 4, 0, 1, 1));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 3, 1, 1, 1));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 2, 1, 1, 1));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 1, 1));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 1));

      repeat (2) @(posedge clk);
      #1;
      chk("rst_wb_vld",    82'(wb_vld),    82'(0));
      chk("rst_occ",       82'(occ),       82'(0));
      chk("rst_can_issue", 82'(can_issue), 82'(1));
      chk("rst_ovf",       82'(ovf),       82'(0));
      chk("rst_wb_tag",    82'(wb_tag),    82'(0));
      chk("rst_wb_res",    wb_res,         82'(0));
      chk("rst_wb_rtyp",   82'(wb_rtyp),   82'(0));
      rst = 1'b0;

      foreach (tbl[i]) apply_row(tbl[i], i);
      chk("sb_drained", 82'(sb.size()), 82'(0));

      // reset mid-operation: two entries queued, tag 32 still in the converter
      apply_row(mk(1, 30, 1, 0, 0, 0, 0, 1, 0, 1), 100);
      apply_row(mk(1, 31, 1, 0, 0, 0, 0, 1, 0, 1), 101);
      apply_row(mk(1, 32, 1, 0, 0, 0, 1, 1, 1, 1), 102);
      apply_row(mk(0, 0, 1, 0, 0, 0, 2, 1, 1, 1), 103);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_wb_vld",    82'(wb_vld),    82'(0));
      chk("arst_occ",       82'(occ),       82'(0));
      chk("arst_can_issue", 82'(can_issue), 82'(1));
      chk("arst_ovf",       82'(ovf),       82'(0));
      chk("arst_wb_tag",    82'(wb_tag),    82'(0));
      sb.delete();
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) apply_row(mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 0), 110 + i);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/ifconv_wb_queue.md
Name: ifconv_wb_queue

Overview:
- Downstream stage of the integer-to-float conversion unit.
- Realigns the issue tag with the converter's 2-cycle result and captures each valid result (82-bit packed FP value, 2-bit ptype) in a small FIFO.
- Drains the FIFO to the FP writeback port with a valid/ready handshake.
- Gives issue logic a credit signal, since the converter itself cannot stall.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- TAG_W, 9, width of the destination/rename tag carried with each conversion.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- clkEn  input  1  pipeline enable, same signal that gates the converter's registers.
- en_in  input  1  conversion issued this cycle; same cycle as the converter's en.
- tag_in  input  TAG_W  tag of the issued conversion.
- res  input  82  converter result; valid 2 clkEn cycles after issue.
- rtyp  input  2  converter result ptype (sngl/dbl/ext encoding), aligned with res.
- can_issue  output  1  at least one free credit; issue logic must not assert en_in when low.
- wb_vld  output  1  head entry valid.
- wb_rdy  input  1  writeback port accepts the head entry.
- wb_res  output  82  head entry result.
- wb_rtyp  output  2  head entry ptype.
- wb_tag  output  TAG_W  head entry tag.
- occ  output  $clog2(DEPTH)+1  FIFO occupancy.
- ovf  output  1  sticky protocol error flag.

Behaviour:
- Reset (async, rst=1):
  - delay-line valids, rd/wr pointers and occ cleared;
  - wb_vld=0, wb_res=0, wb_rtyp=0, wb_tag=0, ovf=0, can_issue=1.
  - An in-flight conversion is discarded; FIFO contents are lost.
- Delay line: two stages (v1/tag1, v2/tag2).
  - When clkEn=1: v1<=en_in, tag1<=tag_in, v2<=v1, tag2<=tag1.
  - When clkEn=0: both stages hold, tracking the converter's held registers.
- Push:
  - push = clkEn & v2; writes {res, rtyp, tag2} at wr_ptr, then wr_ptr++ (mod DEPTH).
  - res/rtyp are sampled in the same cycle v2 is seen, i.e. issue + 2 clkEn edges.
- Pop:
  - pop = wb_vld & wb_rdy; rd_ptr++.
  - Pop is independent of clkEn; the writeback port drains while the pipeline is stalled.
- Outputs:
  - wb_vld = (occ != 0).
  - wb_res/wb_rtyp/wb_tag read combinationally at rd_ptr; they are stable while wb_vld=1 and wb_rdy=0.
- occ update:
  - occ <= occ + push - pop.
  - Simultaneous push and pop leaves occ unchanged.
  - Simultaneous push and pop on a full FIFO is legal; the popped slot is reused next cycle, not the same cycle.
- Latency: no bypass; an empty FIFO pushed at edge N shows wb_vld=1 after edge N. Issue-to-wb_vld minimum is 2 clkEn edges plus 0 extra.
- Credits:
  - can_issue = (occ + v1 + v2) < DEPTH, combinational from registers.
  - A pop in the current cycle does not raise can_issue until the next cycle.
- Error handling:
  - en_in & clkEn & !can_issue, or push while occ==DEPTH and !pop, sets ovf (sticky until rst).
  - An overflowing push is dropped; pointers and occ are unchanged.
- Pointer arithmetic: pointers are $clog2(DEPTH) bits and wrap naturally; occ disambiguates full from empty.
- Results are never reordered; writeback order equals issue order.

Decomposition:
- Shared package: ptype constants (sngl/dbl/ext), the 82-bit packed result width constant, and a typedef for a queue entry {res, rtyp, tag}.
- One natural sub-module: ifconv_wb_fifo, the generic DEPTH x entry-width storage with pointers and occ.
- The top level holds the delay line, the credit logic and ovf.

Test Plan:
- Single issue: rst, then en_in=1, tag_in=9'h05 with clkEn=1, res=82'h1_3FFF_8000_0000_0000_0000 at +2 → wb_vld=1 at +2 edge; wb_tag=5, wb_res matches; with wb_rdy=1, occ returns to 0 next edge.
- Stall alignment: issue tag 7, clkEn=0 for 3 cycles after issue → push occurs only on the 2nd clkEn-high edge; captured res equals the value present then.
- Back-pressure fill: wb_rdy=0, issue every cycle → can_issue falls after 4 issues (occ+inflight=4); occ reaches 4; ovf stays 0.
- Full push/pop: occ=4, wb_rdy=1 with a push arriving → occ stays 4; order preserved across wrap (tags 0..7 emerge 0..7).
- Protocol violation: force en_in while can_issue=0 → ovf=1 and stays 1; no entry corrupted; occ never exceeds 4.
- Reset mid-operation: 2 entries queued plus 1 in flight, assert rst asynchronously mid-cycle → wb_vld=0 immediately, can_issue=1, and no push from the discarded conversion after rst deasserts.
